// File: rtl/lpddr2_seq_pkg.sv
// Shared definitions for the LPDDR2 init sequencer.
// Holds the FSM state encoding, the register word addresses, and the bit
// positions used in the status, event and control registers.
package lpddr2_seq_pkg;

   typedef enum logic [1:0] {
      ST_RESET    = 2'd0,
      ST_WAIT_CAL = 2'd1,
      ST_READY    = 2'd2,
      ST_FAILED   = 2'd3
   } seq_state_t;

   localparam logic [1:0] ADDR_STATUS   = 2'd0;
   localparam logic [1:0] ADDR_EVENTS   = 2'd1;
   localparam logic [1:0] ADDR_CTRL     = 2'd2;
   localparam logic [1:0] ADDR_CAL_TIME = 2'd3;

   localparam int STS_INIT = 0;
   localparam int STS_OK   = 1;
   localparam int STS_FAIL = 2;

   localparam int EVT_READY  = 0;
   localparam int EVT_FAILED = 1;
   localparam int EVT_LOST   = 2;

   localparam int CTRL_RESTART = 0;
   localparam int CTRL_IRQ_EN  = 1;

endpackage

// File: rtl/lpddr2_init_sequencer_if.sv
// Avalon-MM slave bus of the LPDDR2 init sequencer, plus its interrupt line.
// Ports:
//   address[1:0]    word address
//   chipselect      select
//   write_n         write strobe, active low (high with chipselect = read)
//   writedata[31:0] write data
//   readdata[31:0]  registered read data
//   irq             level interrupt
interface lpddr2_init_sequencer_if;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic        irq;

   modport slave  (input address, chipselect, write_n, writedata,
                   output readdata, irq);
   modport master (output address, chipselect, write_n, writedata,
                   input readdata, irq);
endinterface

// File: rtl/lpddr2_status_sync.sv
// Multi-bit flop-chain synchronizer for the LPDDR2 controller status pins.
// Ports:
//   clk, reset_n  clock and asynchronous active-low reset (chain clears to 0)
//   d             asynchronous input bits
//   q             synchronized output, STAGES cycles behind d
module lpddr2_status_sync #(
   parameter int WIDTH  = 3,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [STAGES-1:0][WIDTH-1:0] sync_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) sync_q <= '0;
      else          sync_q <= {sync_q[STAGES-2:0], d};
   end

   assign q = sync_q[STAGES-1];

endmodule

// File: rtl/lpddr2_init_sequencer.sv
// LPDDR2 bring-up and supervision controller.
// Pulses the controller soft reset, waits for calibration with a timeout and
// bounded retries, re-initializes when the link drops, and exposes status,
// sticky events, restart and an interrupt on a 4-word Avalon-MM slave.
// Ports:
//   clk, reset_n      system clock, asynchronous active-low reset
//   status_in[2:0]    async controller status: init_done, cal_success, cal_fail
//   mem_soft_reset_n  soft reset to the LPDDR2 controller, active low
//   mem_ready         high while calibrated and healthy
//   bus               Avalon-MM slave (address/chipselect/write_n/data/irq)
//
// state       | meaning
// ST_RESET    | soft reset held low for RESET_PULSE_CYCLES
// ST_WAIT_CAL | reset released, waiting for init_done & cal_success
// ST_READY    | calibrated; watching for link loss
// ST_FAILED   | retries exhausted; idle until software restart
module lpddr2_init_sequencer
   import lpddr2_seq_pkg::*;
#(
   parameter int TIMEOUT_CYCLES     = 50000000,
   parameter int MAX_RETRIES        = 3,
   parameter int RESET_PULSE_CYCLES = 16,
   parameter int SYNC_STAGES        = 2
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic [2:0]              status_in,
   output logic                    mem_soft_reset_n,
   output logic                    mem_ready,
   lpddr2_init_sequencer_if.slave  bus
);

   localparam int TIMER_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam int PULSE_W = (RESET_PULSE_CYCLES > 1) ? $clog2(RESET_PULSE_CYCLES) : 1;
   localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
   localparam logic [PULSE_W-1:0] PULSE_LAST = PULSE_W'(RESET_PULSE_CYCLES - 1);
   localparam logic [3:0]         RETRY_MAX  = 4'(MAX_RETRIES);

   logic [2:0]         status_s;
   seq_state_t         state_q, state_d;
   logic [PULSE_W-1:0] pulse_q, pulse_d;
   logic [TIMER_W-1:0] timer_q, timer_d;
   logic [3:0]         retry_q, retry_d;
   logic [2:0]         events_q, evt_set, evt_w1c;
   logic               cal_load;
   logic [31:0]        cal_time_q;
   logic               irq_en_q, irq_q;
   logic [31:0]        readdata_q;
   logic               msr_n_q, ready_q;
   logic               wr_en, rd_en, restart;
   logic               sts_init, sts_ok, sts_fail;
   logic               unused_wdata;

   lpddr2_status_sync #(.WIDTH(3), .STAGES(SYNC_STAGES)) u_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .d       (status_in),
      .q       (status_s)
   );

   assign sts_init = status_s[STS_INIT];
   assign sts_ok   = status_s[STS_OK];
   assign sts_fail = status_s[STS_FAIL];

   assign wr_en   = bus.chipselect & ~bus.write_n;
   assign rd_en   = bus.chipselect &  bus.write_n;
   assign restart = wr_en && (bus.address == ADDR_CTRL) && bus.writedata[CTRL_RESTART];
   assign evt_w1c = (wr_en && (bus.address == ADDR_EVENTS)) ? bus.writedata[2:0] : 3'b000;
   assign unused_wdata = ^bus.writedata[31:3];

   always_comb begin
      state_d  = state_q;
      pulse_d  = '0;
      timer_d  = timer_q;
      retry_d  = retry_q;
      evt_set  = 3'b000;
      cal_load = 1'b0;
      case (state_q)
         ST_RESET: begin
            if (pulse_q == PULSE_LAST) begin
               state_d = ST_WAIT_CAL;
               timer_d = '0;
            end else begin
               pulse_d = pulse_q + 1'b1;
            end
         end
         ST_WAIT_CAL: begin
            timer_d = timer_q + 1'b1;
            // fail is checked first so a simultaneous ok is ignored
            if (sts_fail || (timer_q == TIMER_LAST)) begin
               if (retry_q < RETRY_MAX) begin
                  retry_d = retry_q + 1'b1;
                  state_d = ST_RESET;
               end else begin
                  evt_set[EVT_FAILED] = 1'b1;
                  state_d             = ST_FAILED;
               end
            end else if (sts_init && sts_ok) begin
               cal_load           = 1'b1;
               evt_set[EVT_READY] = 1'b1;
               state_d            = ST_READY;
            end
         end
         ST_READY: begin
            if (!sts_init || !sts_ok || sts_fail) begin
               evt_set[EVT_LOST] = 1'b1;
               retry_d           = '0;
               state_d           = ST_RESET;
            end
         end
         default: ;
      endcase
      // software restart wins over whatever the FSM decided this cycle
      if (restart) begin
         state_d  = ST_RESET;
         pulse_d  = '0;
         retry_d  = '0;
         evt_set  = 3'b000;
         cal_load = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_RESET;
         pulse_q <= '0;
         timer_q <= '0;
         retry_q <= '0;
         msr_n_q <= 1'b0;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pulse_q <= pulse_d;
         timer_q <= timer_d;
         retry_q <= retry_d;
         // outputs decoded from next state so they switch with the state flops, glitch-free
         msr_n_q <= (state_d != ST_RESET);
         ready_q <= (state_d == ST_READY);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         events_q   <= '0;
         cal_time_q <= '0;
         irq_en_q   <= 1'b0;
         irq_q      <= 1'b0;
         readdata_q <= '0;
      end else begin
         // a set in the same cycle as a W1C keeps the bit
         events_q <= (events_q & ~evt_w1c) | evt_set;
         if (cal_load) cal_time_q <= 32'(timer_q);
         if (wr_en && (bus.address == ADDR_CTRL)) irq_en_q <= bus.writedata[CTRL_IRQ_EN];
         irq_q <= irq_en_q & (|events_q);
         if (rd_en) begin
            case (bus.address)
               ADDR_STATUS:   readdata_q <= {22'd0, retry_q, ready_q, state_q, status_s};
               ADDR_EVENTS:   readdata_q <= {29'd0, events_q};
               ADDR_CTRL:     readdata_q <= {30'd0, irq_en_q, 1'b0};
               default:       readdata_q <= cal_time_q;
            endcase
         end
      end
   end

   assign mem_soft_reset_n = msr_n_q;
   assign mem_ready        = ready_q;
   assign bus.readdata     = readdata_q;
   assign bus.irq          = irq_q;

endmodule
